// File: rtl/next_pc_predictor_if.sv
// Fetch/resolve/redirect bundle for next_pc_predictor.
// NPC_GSHARE_EN adds the global-history ports Fetch_GHR and Resolve_GHR.
interface next_pc_predictor_if #(
  parameter int ADDR_W = 32
`ifdef NPC_GSHARE_EN
  , parameter int IDX_W = 4
`endif
);
  logic [ADDR_W-1:0] Fetch_PC;
  logic [ADDR_W-1:0] Predicted_PC;
  logic              Predict_Taken;
  logic              Resolve_Valid;
  logic [ADDR_W-1:0] Resolve_PC;
  logic              Resolve_IsJump;
  logic              Resolve_Taken;
  logic [ADDR_W-1:0] Resolve_Target;
  logic              Resolve_PredTaken;
  logic [ADDR_W-1:0] Resolve_PredPC;
  logic              Redirect;
  logic [ADDR_W-1:0] Redirect_PC;
`ifdef NPC_GSHARE_EN
  logic [IDX_W-1:0]  Fetch_GHR;
  logic [IDX_W-1:0]  Resolve_GHR;

  modport master (
    output Fetch_PC, Resolve_Valid, Resolve_PC, Resolve_IsJump, Resolve_Taken,
           Resolve_Target, Resolve_PredTaken, Resolve_PredPC, Resolve_GHR,
    input  Predicted_PC, Predict_Taken, Redirect, Redirect_PC, Fetch_GHR
  );
  modport slave (
    input  Fetch_PC, Resolve_Valid, Resolve_PC, Resolve_IsJump, Resolve_Taken,
           Resolve_Target, Resolve_PredTaken, Resolve_PredPC, Resolve_GHR,
    output Predicted_PC, Predict_Taken, Redirect, Redirect_PC, Fetch_GHR
  );
`else
  modport master (
    output Fetch_PC, Resolve_Valid, Resolve_PC, Resolve_IsJump, Resolve_Taken,
           Resolve_Target, Resolve_PredTaken, Resolve_PredPC,
    input  Predicted_PC, Predict_Taken, Redirect, Redirect_PC
  );
  modport slave (
    input  Fetch_PC, Resolve_Valid, Resolve_PC, Resolve_IsJump, Resolve_Taken,
           Resolve_Target, Resolve_PredTaken, Resolve_PredPC,
    output Predicted_PC, Predict_Taken, Redirect, Redirect_PC
  );
`endif
endinterface

// File: rtl/next_pc_predictor.sv
// Direct-mapped BTB next-PC predictor trained by EX-stage resolution, with registered redirect.
// Define NPC_GSHARE_EN to replace per-entry counters by a GHR-indexed gshare counter array.
module next_pc_predictor #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 10,
  parameter int CTR_W  = 2
) (
  input logic               CLK,
  input logic               RESET,
  next_pc_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0]  CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0]  CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0]  CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_MIN = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0]  CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+2+TAG_W-1:IDX_W+2];
  endfunction

  function automatic logic [CTR_W-1:0] sat_ctr(input logic [CTR_W-1:0] c, input logic up);
    if (up) begin
      return (c == CTR_MAX) ? c : c + CTR_ONE;
    end else begin
      return (c == CTR_MIN) ? c : c - CTR_ONE;
    end
  endfunction

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic              isjump_r [ENTRIES];
`ifdef NPC_GSHARE_EN
  logic [CTR_W-1:0]  pht_r    [ENTRIES];
  logic [IDX_W-1:0]  ghr_r;
`else
  logic [CTR_W-1:0]  ctr_r    [ENTRIES];
`endif
  logic              redirect_r;
  logic [ADDR_W-1:0] redirect_pc_r;

  logic [IDX_W-1:0]  f_idx_s;
  logic              f_hit_s;
  logic              f_dir_s;
  logic [IDX_W-1:0]  r_idx_s;
  logic              r_hit_s;
  logic              r_taken_s;
  logic              mispredict_s;
  logic [ADDR_W-1:0] r_next_pc_s;

  // Fetch-side lookup on registered table contents (no update bypass)
  always_comb begin
    f_idx_s = idx_of(bus.Fetch_PC);
    f_hit_s = valid_r[f_idx_s] && (tag_r[f_idx_s] == tag_of(bus.Fetch_PC));
`ifdef NPC_GSHARE_EN
    f_dir_s = pht_r[f_idx_s ^ ghr_r][CTR_W-1];
`else
    f_dir_s = ctr_r[f_idx_s][CTR_W-1];
`endif
    bus.Predict_Taken = f_hit_s && (isjump_r[f_idx_s] || f_dir_s);
    if (bus.Predict_Taken) begin
      bus.Predicted_PC = target_r[f_idx_s];
    end else begin
      bus.Predicted_PC = bus.Fetch_PC + PC_STEP;
    end
  end

  // Resolve-side lookup and misprediction detection; jumps always count as taken
  always_comb begin
    r_idx_s      = idx_of(bus.Resolve_PC);
    r_hit_s      = valid_r[r_idx_s] && (tag_r[r_idx_s] == tag_of(bus.Resolve_PC));
    r_taken_s    = bus.Resolve_Taken || bus.Resolve_IsJump;
    mispredict_s = bus.Resolve_Valid &&
                   ((r_taken_s != bus.Resolve_PredTaken) ||
                    (r_taken_s && (bus.Resolve_Target != bus.Resolve_PredPC)));
    if (r_taken_s) begin
      r_next_pc_s = bus.Resolve_Target;
    end else begin
      r_next_pc_s = bus.Resolve_PC + PC_STEP;
    end
  end

  // BTB training and redirect register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {ADDR_W{1'b0}};
        isjump_r[i] <= 1'b0;
`ifndef NPC_GSHARE_EN
        ctr_r[i]    <= CTR_WNT;
`endif
      end
      redirect_r    <= 1'b0;
      redirect_pc_r <= {ADDR_W{1'b0}};
    end else if (bus.Resolve_Valid) begin
      if (r_hit_s) begin
`ifndef NPC_GSHARE_EN
        if (!bus.Resolve_IsJump) begin
          ctr_r[r_idx_s] <= sat_ctr(ctr_r[r_idx_s], r_taken_s);
        end
`endif
        if (r_taken_s) begin
          target_r[r_idx_s] <= bus.Resolve_Target;
          isjump_r[r_idx_s] <= bus.Resolve_IsJump;
        end
      end else if (r_taken_s) begin
        valid_r[r_idx_s]  <= 1'b1;
        tag_r[r_idx_s]    <= tag_of(bus.Resolve_PC);
        target_r[r_idx_s] <= bus.Resolve_Target;
        isjump_r[r_idx_s] <= bus.Resolve_IsJump;
`ifndef NPC_GSHARE_EN
        ctr_r[r_idx_s]    <= CTR_WT;
`endif
      end
      redirect_r <= mispredict_s;
      if (mispredict_s) begin
        redirect_pc_r <= r_next_pc_s;
      end
    end else begin
      redirect_r <= 1'b0;
    end
  end

`ifdef NPC_GSHARE_EN
  // Gshare counters train at the history snapshot taken at fetch; GHR is repaired on a mispredict
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= CTR_WNT;
      end
      ghr_r <= {IDX_W{1'b0}};
    end else if (bus.Resolve_Valid) begin
      if (!bus.Resolve_IsJump) begin
        pht_r[r_idx_s ^ bus.Resolve_GHR] <= sat_ctr(pht_r[r_idx_s ^ bus.Resolve_GHR], r_taken_s);
      end
      if (mispredict_s) begin
        ghr_r <= bus.Resolve_IsJump ? bus.Resolve_GHR
                                    : {bus.Resolve_GHR[IDX_W-2:0], r_taken_s};
      end else if (!bus.Resolve_IsJump) begin
        ghr_r <= {ghr_r[IDX_W-2:0], r_taken_s};
      end
    end
  end

  assign bus.Fetch_GHR = ghr_r;
`endif

  assign bus.Redirect    = redirect_r;
  assign bus.Redirect_PC = redirect_pc_r;
endmodule

// File: tb/tb_next_pc_predictor.sv
// Scoreboard bench for next_pc_predictor: per-cycle prediction and redirect expectations are queued and checked.
module tb_next_pc_predictor;
  logic CLK;
  logic RESET;
  int   total;
  int   bad;
  int   step_n;

  next_pc_predictor_if #(.ADDR_W(32)) bus ();

  next_pc_predictor #(.ADDR_W(32), .IDX_W(4), .TAG_W(10), .CTR_W(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        pt;
    logic [31:0] ppc;
  } pred_exp_t;

  typedef struct {
    logic        rd;
    logic [31:0] rdpc;
  } redir_exp_t;

  pred_exp_t  pred_q[$];
  redir_exp_t redir_q[$];

  localparam logic [31:0] B   = 32'h0040_0010;
  localparam logic [31:0] T   = 32'h0040_0100;
  localparam logic [31:0] J   = 32'h0040_0020;
  localparam logic [31:0] JT  = 32'h0040_0200;
  localparam logic [31:0] A   = 32'h0040_0060;
  localparam logic [31:0] AT  = 32'h0040_0300;
  localparam logic [31:0] AT2 = 32'h0040_0400;
  localparam logic [31:0] C   = 32'h0040_0030;
  localparam logic [31:0] CT  = 32'h0040_0500;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h exp=%h", tag, step_n, got, exp);
    end
  endtask

  // One cycle: drive, check combinational prediction, then check the registered redirect
  task automatic step(input logic rst, input logic [31:0] fpc, input logic chk,
                      input logic ept, input logic [31:0] eppc,
                      input logic rv, input logic [31:0] rpc, input logic rj,
                      input logic rt, input logic [31:0] rtgt,
                      input logic rpt, input logic [31:0] rppc,
                      input logic erd, input logic [31:0] erdpc);
    pred_exp_t  pe;
    redir_exp_t re;
    step_n++;
    RESET                 = rst;
    bus.Fetch_PC          = fpc;
    bus.Resolve_Valid     = rv;
    bus.Resolve_PC        = rpc;
    bus.Resolve_IsJump    = rj;
    bus.Resolve_Taken     = rt | rj;
    bus.Resolve_Target    = rtgt;
    bus.Resolve_PredTaken = rpt;
    bus.Resolve_PredPC    = rppc;
    if (chk) begin
      pred_q.push_back('{pt: ept, ppc: eppc});
    end
    redir_q.push_back('{rd: erd, rdpc: erdpc});
    #1;
    if (chk) begin
      pe = pred_q.pop_front();
      check("predict_taken", {31'd0, bus.Predict_Taken}, {31'd0, pe.pt});
      check("predicted_pc", bus.Predicted_PC, pe.ppc);
    end
    @(posedge CLK);
    #1;
    re = redir_q.pop_front();
    check("redirect", {31'd0, bus.Redirect}, {31'd0, re.rd});
    check("redirect_pc", bus.Redirect_PC, re.rdpc);
    @(negedge CLK);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    step_n = 0;
    RESET  = 1'b1;
    bus.Fetch_PC          = B;
    bus.Resolve_Valid     = 1'b0;
    bus.Resolve_PC        = 32'h0;
    bus.Resolve_IsJump    = 1'b0;
    bus.Resolve_Taken     = 1'b0;
    bus.Resolve_Target    = 32'h0;
    bus.Resolve_PredTaken = 1'b0;
    bus.Resolve_PredPC    = 32'h0;
`ifdef NPC_GSHARE_EN
    bus.Resolve_GHR       = 4'h0;
`endif
    @(negedge CLK);
    //   rst   fetch       chk  pt    ppc         rv    rpc  rj    rt    tgt  rpt   rppc        rd    rdpc
    step(1'b1, B,          1'b1, 1'b0, B + 32'd4,  1'b1, B,   1'b0, 1'b1, T,   1'b0, B + 32'd4,  1'b0, 32'h0);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b0, B,   1'b0, 1'b0, T,   1'b0, 32'h0,      1'b0, 32'h0);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b1, B,   1'b0, 1'b1, T,   1'b0, B + 32'd4,  1'b1, T);
    step(1'b0, B,          1'b1, 1'b1, T,          1'b0, B,   1'b0, 1'b0, T,   1'b0, 32'h0,      1'b0, T);
    step(1'b0, B,          1'b1, 1'b1, T,          1'b1, B,   1'b0, 1'b0, T,   1'b1, T,          1'b1, B + 32'd4);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b1, B,   1'b0, 1'b0, T,   1'b1, T,          1'b1, B + 32'd4);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b0, B,   1'b0, 1'b0, T,   1'b0, 32'h0,      1'b0, B + 32'd4);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b1, B,   1'b0, 1'b0, T,   1'b0, B + 32'd4,  1'b0, B + 32'd4);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b1, B,   1'b0, 1'b1, T,   1'b0, B + 32'd4,  1'b1, T);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b0, B,   1'b0, 1'b0, T,   1'b0, 32'h0,      1'b0, T);
    // Jump entry keeps predicting taken while the in-entry counter drifts down
    step(1'b0, J,          1'b1, 1'b0, J + 32'd4,  1'b1, J,   1'b1, 1'b1, JT,  1'b0, J + 32'd4,  1'b1, JT);
    step(1'b0, J,          1'b1, 1'b1, JT,         1'b1, J,   1'b0, 1'b0, JT,  1'b1, JT,         1'b1, J + 32'd4);
    step(1'b0, J,          1'b1, 1'b1, JT,         1'b0, J,   1'b0, 1'b0, JT,  1'b0, 32'h0,      1'b0, J + 32'd4);
    step(1'b0, J,          1'b1, 1'b1, JT,         1'b1, J,   1'b0, 1'b0, JT,  1'b1, JT,         1'b1, J + 32'd4);
    step(1'b0, J,          1'b1, 1'b1, JT,         1'b0, J,   1'b0, 1'b0, JT,  1'b0, 32'h0,      1'b0, J + 32'd4);
    // Aliasing PC with the same index replaces the jump entry
    step(1'b0, A,          1'b1, 1'b0, A + 32'd4,  1'b1, A,   1'b0, 1'b1, AT,  1'b0, A + 32'd4,  1'b1, AT);
    step(1'b0, J,          1'b1, 1'b0, J + 32'd4,  1'b0, A,   1'b0, 1'b0, AT,  1'b0, 32'h0,      1'b0, AT);
    step(1'b0, A,          1'b1, 1'b1, AT,         1'b0, A,   1'b0, 1'b0, AT,  1'b0, 32'h0,      1'b0, AT);
    step(1'b0, A,          1'b1, 1'b1, AT,         1'b1, A,   1'b0, 1'b1, AT,  1'b1, AT,         1'b0, AT);
    step(1'b0, A,          1'b1, 1'b1, AT,         1'b1, A,   1'b0, 1'b1, AT2, 1'b1, AT,         1'b1, AT2);
    step(1'b0, A,          1'b1, 1'b1, AT2,        1'b0, A,   1'b0, 1'b0, AT2, 1'b0, 32'h0,      1'b0, AT2);
    step(1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,   1'b0, A,   1'b0, 1'b0, AT2, 1'b0, 32'h0,      1'b0, AT2);
    step(1'b0, B,          1'b1, 1'b0, B + 32'd4,  1'b1, B,   1'b0, 1'b0, T,   1'b0, 32'h1234_5678, 1'b0, AT2);
    // Reset wins over a simultaneous resolve
    step(1'b1, C,          1'b1, 1'b0, C + 32'd4,  1'b1, C,   1'b0, 1'b1, CT,  1'b0, C + 32'd4,  1'b0, 32'h0);
    step(1'b0, C,          1'b1, 1'b0, C + 32'd4,  1'b0, C,   1'b0, 1'b0, CT,  1'b0, 32'h0,      1'b0, 32'h0);
    step(1'b0, A,          1'b1, 1'b0, A + 32'd4,  1'b1, C,   1'b0, 1'b0, CT,  1'b1, CT,         1'b1, C + 32'd4);
    step(1'b0, C,          1'b1, 1'b0, C + 32'd4,  1'b0, C,   1'b0, 1'b0, CT,  1'b0, 32'h0,      1'b0, C + 32'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
